// File: rtl/thirty_two_bit_full_adder_pkg.sv
// Shared adder constants and types for the oscillator datapath blocks.
package thirty_two_bit_full_adder_pkg;

  // Operand / sum width used by phase accumulation and general add
  localparam int ADDER_WIDTH = 32;

  // Result of one add: carry out of the top bit plus the modular sum
  typedef struct packed {
    logic                   c_out;
    logic [ADDER_WIDTH-1:0] sum;
  } add_res_t;

  // Operand bundle for consumers that pass adds around as one request
  typedef struct packed {
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   c_in;
  } add_req_t;

endpackage

// File: rtl/thirty_two_bit_full_adder_full_adder.sv
// One-bit full adder cell; the ripple chain is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term shared by sum and carry
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/thirty_two_bit_full_adder.sv
// 32-bit ripple-carry adder: combinational {c_out,sum} plus a registered copy.
module thirty_two_bit_full_adder
  import thirty_two_bit_full_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             c_out_q
);

  // carry[i] enters bit i; carry[WIDTH] leaves the top bit
  logic [WIDTH:0] carry;

  assign carry[0] = c_in;

  // Structural ripple chain, one full_adder per bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign c_out = carry[WIDTH];

  // Registered copy of the result; reset clears only these registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      c_out_q <= c_out;
    end
  end

endmodule

// File: tb/tb_thirty_two_bit_full_adder.sv
// Bench for thirty_two_bit_full_adder: directed vectors, register sequences, random stream.
module tb_thirty_two_bit_full_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        c_in = 1'b0;
  logic [31:0] sum, sum_q;
  logic        c_out, c_out_q;

  int n_chk = 0;
  int n_pass = 0;

  thirty_two_bit_full_adder dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .sum     (sum),
    .c_out   (c_out),
    .sum_q   (sum_q),
    .c_out_q (c_out_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t tbl[7];

  // Reference: exact 33-bit arithmetic
  function automatic logic [32:0] ref_add(logic [31:0] x, logic [31:0] y, logic ci);
    return {1'b0, x} + {1'b0, y} + {32'b0, ci};
  endfunction

  task automatic check(string name, logic [32:0] act, logic [32:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [32:0] exp;
    logic [31:0] pa, pb;
    logic        pc;

    tbl[0] = '{32'd5,        32'd7,        1'b0, 32'd12,       1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    tbl[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b1};
    tbl[4] = '{32'h0,        32'h0,        1'b0, 32'h0,        1'b0};
    tbl[5] = '{32'h0,        32'h0,        1'b1, 32'h1,        1'b0};
    tbl[6] = '{32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 1'b0};

    // Directed combinational vectors (reset held: must not mask sum/c_out)
    for (int i = 0; i < 7; i++) begin
      a = tbl[i].a; b = tbl[i].b; c_in = tbl[i].ci;
      #10;
      check($sformatf("vec%0d", i), {c_out, sum}, {tbl[i].co, tbl[i].s});
    end

    // Reset held for two edges clears registers
    @(negedge clk);
    reset = 1'b1; a = 32'd9; b = 32'd9; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_regs", {c_out_q, sum_q}, 33'h0);
    check("comb_in_reset", {c_out, sum}, 33'd18);

    // Release with 1+2+1 -> 4 one edge later
    @(negedge clk);
    reset = 1'b0; a = 32'd1; b = 32'd2; c_in = 1'b1;
    @(posedge clk); #1;
    check("release_load", {c_out_q, sum_q}, 33'd4);

    // Registered wrap-around
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h0; c_in = 1'b1;
    @(posedge clk); #1;
    check("reg_wrap", {c_out_q, sum_q}, {1'b1, 32'h0});

    // Mid-stream reset clears at that edge
    @(negedge clk);
    reset = 1'b1; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    check("midstream_reset", {c_out_q, sum_q}, 33'h0);

    // Reload at first edge with reset low
    @(negedge clk);
    reset = 1'b0; a = 32'd10; b = 32'd20; c_in = 1'b0;
    @(posedge clk); #1;
    check("reload", {c_out_q, sum_q}, 33'd30);

    // Random registered stream: one-cycle latency against previous inputs
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
      a = pa; b = pb; c_in = pc;
      @(posedge clk); #1;
      check($sformatf("reg_rand%0d", i), {c_out_q, sum_q}, ref_add(pa, pb, pc));
    end

    // Random combinational stream, 33-bit compare every 10 ns
    for (int i = 0; i < 20000; i++) begin
      a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1));
      #10;
      exp = ref_add(a, b, c_in);
      n_chk++;
      if ({c_out, sum} === exp) n_pass++;
      else $display("FAIL rand iter %0d a=%h b=%h c_in=%b: got %h expected %h",
                    i, a, b, c_in, {c_out, sum}, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
